ps_ddr_rd_master: RTL

Read-burst engine between the PS-side read controller and the DDR memory port. It accepts a single read command (start, byte address, byte length) and splits it into memory bursts that respect a maximum length and an address boundary. It returns the read words as a qualified data stream and signals completion with a one-cycle finish pulse. The block sits directly downstream of the read controller's command outputs and directly upstream of that controller's data/finish inputs.

---
 rtl/ps_ddr_rd_master.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ps_ddr_rd_master.sv
// Read-burst engine: splits one PS read command into DDR bursts capped by
// MAX_BURST beats and never crossing a BOUNDARY-byte line, and forwards the beats.
module ps_ddr_rd_master #(
    parameter int MAX_BURST = 16,
    parameter int BOUNDARY  = 4096
) (
    input  logic        ps_clk,
    input  logic        ps_rst,
    input  logic        ps_ddr_rd_start,
    input  logic [31:0] ps_ddr_rd_addr,
    input  logic [31:0] ps_ddr_rd_length,
    output logic        ps_ddr_rd_en,
    output logic [31:0] ps_ddr_rd_data,
    output logic        ps_ddr_rd_finish,
    output logic        ps_ddr_rd_busy,
    output logic        ps_ddr_rd_err,
    output logic        mem_rd_req,
    output logic [31:0] mem_rd_addr,
    output logic [8:0]  mem_rd_len,
    input  logic        mem_rd_ack,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    input  logic        mem_rd_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] MAX_BURST_W = 32'(MAX_BURST);
    localparam logic [31:0] BOUNDARY_W  = 32'(BOUNDARY);

    state_t      state_r;
    logic [31:0] cur_addr_r;
    logic [29:0] remaining_r;
    logic [8:0]  beat_cnt_r;
    logic [31:0] start_addr_s;
    logic [29:0] start_words_s;
    logic        unused_s;

    // Burst size is the smallest of the words left, the burst cap and the
    // words left before the next boundary line.
    function automatic logic [8:0] calc_beats(input logic [31:0] addr, input logic [29:0] rem);
        logic [31:0] bnd_words;
        logic [8:0]  lim;
        bnd_words = (BOUNDARY_W - (addr & (BOUNDARY_W - 32'd1))) >> 2;
        lim = MAX_BURST_W[8:0];
        if (bnd_words < MAX_BURST_W) begin
            lim = bnd_words[8:0];
        end
        if ({2'b00, rem} < {23'd0, lim}) begin
            lim = rem[8:0];
        end
        return lim;
    endfunction

    assign start_addr_s  = {ps_ddr_rd_addr[31:2], 2'b00};
    assign start_words_s = ps_ddr_rd_length[31:2];
    assign unused_s      = ^{ps_ddr_rd_addr[1:0], ps_ddr_rd_length[1:0]};

    // Command FSM, burst bookkeeping, beat forwarding and protocol error tracking.
    always_ff @(posedge ps_clk or negedge ps_rst) begin
        if (!ps_rst) begin
            state_r          <= IDLE;
            cur_addr_r       <= 32'd0;
            remaining_r      <= 30'd0;
            beat_cnt_r       <= 9'd0;
            ps_ddr_rd_en     <= 1'b0;
            ps_ddr_rd_data   <= 32'd0;
            ps_ddr_rd_finish <= 1'b0;
            ps_ddr_rd_busy   <= 1'b0;
            ps_ddr_rd_err    <= 1'b0;
            mem_rd_req       <= 1'b0;
            mem_rd_addr      <= 32'd0;
            mem_rd_len       <= 9'd0;
        end else begin
            ps_ddr_rd_en     <= 1'b0;
            ps_ddr_rd_finish <= 1'b0;
            if (mem_rd_valid && (state_r == DATA)) begin
                ps_ddr_rd_en   <= 1'b1;
                ps_ddr_rd_data <= mem_rd_data;
            end
            case (state_r)
                IDLE: begin
                    if (ps_ddr_rd_start) begin
                        cur_addr_r     <= start_addr_s;
                        remaining_r    <= start_words_s;
                        ps_ddr_rd_busy <= 1'b1;
                        // a stray beat in the start cycle still counts against the new command
                        ps_ddr_rd_err  <= mem_rd_valid;
                        if (start_words_s == 30'd0) begin
                            state_r          <= DONE;
                            ps_ddr_rd_finish <= 1'b1;
                        end else begin
                            state_r     <= REQ;
                            mem_rd_req  <= 1'b1;
                            mem_rd_addr <= start_addr_s;
                            mem_rd_len  <= calc_beats(start_addr_s, start_words_s);
                        end
                    end else if (mem_rd_valid) begin
                        ps_ddr_rd_err <= 1'b1;
                    end
                end
                REQ: begin
                    if (mem_rd_valid) begin
                        ps_ddr_rd_err <= 1'b1;
                    end
                    if (mem_rd_ack) begin
                        mem_rd_req  <= 1'b0;
                        cur_addr_r  <= cur_addr_r + {21'd0, mem_rd_len, 2'b00};
                        remaining_r <= remaining_r - {21'd0, mem_rd_len};
                        beat_cnt_r  <= mem_rd_len;
                        state_r     <= DATA;
                    end
                end
                DATA: begin
                    if (mem_rd_valid) begin
                        beat_cnt_r <= beat_cnt_r - 9'd1;
                        if (beat_cnt_r == 9'd1) begin
                            if (!mem_rd_last) begin
                                ps_ddr_rd_err <= 1'b1;
                            end
                            if (remaining_r != 30'd0) begin
                                state_r     <= REQ;
                                mem_rd_req  <= 1'b1;
                                mem_rd_addr <= cur_addr_r;
                                mem_rd_len  <= calc_beats(cur_addr_r, remaining_r);
                            end else begin
                                state_r          <= DONE;
                                ps_ddr_rd_finish <= 1'b1;
                            end
                        end else if (mem_rd_last) begin
                            ps_ddr_rd_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (mem_rd_valid) begin
                        ps_ddr_rd_err <= 1'b1;
                    end
                    ps_ddr_rd_busy <= 1'b0;
                    state_r        <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
